// File: rtl/regs_scoreboard.sv
// regs_scoreboard: RV32I integer register file with a per-register pending-write scoreboard.
//   Decode reads rs1/rs2 combinationally, with a write-first bypass from writeback. Decode also
//   issues writes that are counted per destination. stall_o is raised while a source operand still
//   has a pending producer, or while the destination counter is full.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rs1/rs2_addr_i, _data_o   decode read ports (combinational, write-first bypass)
//   issue_valid/rd/wen_i      instruction leaving decode, and its destination
//   flush_i                   cancels this cycle's issue, so no counter increment
//   wb_wen/addr/data_i        writeback port
//   stall_o                   RAW hazard or counter saturation (combinational)
//   pending_o                 per-register "write outstanding" flags (registered)
//   underflow_o               one-cycle pulse after a writeback to a register with nothing pending

// One non-zero register: data word, pending-write counter and its hazard terms.
module regs_sb_slice #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter int IDX    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_wen,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_issue_valid,
  input  logic              i_issue_wen,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic              i_flush,
  input  logic              i_stall,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hazard,
  output logic              o_sat,
  output logic              o_uf_hit,
  output logic              o_pending
);
  localparam logic [ADDR_W-1:0] ADDR    = ADDR_W'(IDX);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_pending;
  logic              w_wb_hit, w_inc, w_dec;

  assign w_wb_hit = i_wb_wen && (i_wb_addr == ADDR);
  assign w_inc    = i_issue_valid && i_issue_wen && (i_issue_rd == ADDR) && !i_flush && !i_stall;
  assign w_dec    = w_wb_hit && (r_cnt != '0);

  // Saturation is handled by stall_o, which blocks w_inc at CNT_MAX unless a writeback
  // retires one in the same cycle; w_dec is gated at zero, so no wrap in either direction.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_inc && !w_dec)      w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_inc && w_dec) w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wb_hit) r_data <= i_wb_data;
      r_cnt     <= w_cnt_nxt;
      r_pending <= (w_cnt_nxt != '0);
    end
  end

  // A writeback landing now retires one pending write, so the operand is free if it was the last.
  assign o_hazard  = r_cnt > {{(CNT_W-1){1'b0}}, w_wb_hit};
  assign o_sat     = (r_cnt == CNT_MAX) && !w_wb_hit;
  assign o_uf_hit  = w_wb_hit && (r_cnt == '0);
  assign o_data    = r_data;
  assign o_pending = r_pending;
endmodule

module regs_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    rs1_addr_i,
  input  logic [ADDR_W-1:0]    rs2_addr_i,
  output logic [DATA_W-1:0]    rs1_data_o,
  output logic [DATA_W-1:0]    rs2_data_o,
  input  logic                 issue_valid_i,
  input  logic [ADDR_W-1:0]    issue_rd_i,
  input  logic                 issue_wen_i,
  input  logic                 flush_i,
  input  logic                 wb_wen_i,
  input  logic [ADDR_W-1:0]    wb_addr_i,
  input  logic [DATA_W-1:0]    wb_data_i,
  output logic                 stall_o,
  output logic [2**ADDR_W-1:0] pending_o,
  output logic                 underflow_o
);
  localparam int REG_NUM = 2**ADDR_W;

  logic [REG_NUM-1:0][DATA_W-1:0] w_rdata;
  logic [REG_NUM-1:0]             w_haz, w_sat, w_uf_hit, w_pend;
  logic                           w_stall;
  logic                           r_underflow;

  // x0 has no storage and no counter: reads zero, never busy, never saturates.
  assign w_rdata[0]  = '0;
  assign w_haz[0]    = 1'b0;
  assign w_sat[0]    = 1'b0;
  assign w_uf_hit[0] = 1'b0;
  assign w_pend[0]   = 1'b0;

  for (genvar g = 1; g < REG_NUM; g++) begin : g_reg
    regs_sb_slice #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .IDX(g)) u_slice (
      .clk           (clk),
      .rst           (rst),
      .i_wb_wen      (wb_wen_i),
      .i_wb_addr     (wb_addr_i),
      .i_wb_data     (wb_data_i),
      .i_issue_valid (issue_valid_i),
      .i_issue_wen   (issue_wen_i),
      .i_issue_rd    (issue_rd_i),
      .i_flush       (flush_i),
      .i_stall       (w_stall),
      .o_data        (w_rdata[g]),
      .o_hazard      (w_haz[g]),
      .o_sat         (w_sat[g]),
      .o_uf_hit      (w_uf_hit[g]),
      .o_pending     (w_pend[g])
    );
  end

  assign w_stall = issue_valid_i &&
                   (w_haz[rs1_addr_i] || w_haz[rs2_addr_i] || (issue_wen_i && w_sat[issue_rd_i]));

  assign rs1_data_o = (wb_wen_i && wb_addr_i == rs1_addr_i && rs1_addr_i != '0) ? wb_data_i
                                                                                  : w_rdata[rs1_addr_i];
  assign rs2_data_o = (wb_wen_i && wb_addr_i == rs2_addr_i && rs2_addr_i != '0) ? wb_data_i
                                                                                  : w_rdata[rs2_addr_i];

  always_ff @(posedge clk) begin
    if (rst) r_underflow <= 1'b0;
    else     r_underflow <= |w_uf_hit;
  end

  assign stall_o     = w_stall;
  assign pending_o   = w_pend;
  assign underflow_o = r_underflow;
endmodule
